// File: rtl/tone_pkg.sv
// Note codes, nominal periods and classification thresholds shared by the tone decoder.
package tone_pkg;

  localparam int unsigned PERIOD_W  = 20;
  localparam int unsigned CODE_W    = 5;
  localparam int unsigned NUM_NOTES = 21;
  localparam int unsigned NUM_THR   = 22;

  localparam logic [CODE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [CODE_W-1:0] MIN_DO = 5'd1;
  localparam logic [CODE_W-1:0] MIN_RE = 5'd2;
  localparam logic [CODE_W-1:0] MIN_MI = 5'd3;
  localparam logic [CODE_W-1:0] MIN_FA = 5'd4;
  localparam logic [CODE_W-1:0] MIN_SO = 5'd5;
  localparam logic [CODE_W-1:0] MIN_LA = 5'd6;
  localparam logic [CODE_W-1:0] MIN_XI = 5'd7;
  localparam logic [CODE_W-1:0] MID_DO = 5'd8;
  localparam logic [CODE_W-1:0] MID_RE = 5'd9;
  localparam logic [CODE_W-1:0] MID_MI = 5'd10;
  localparam logic [CODE_W-1:0] MID_FA = 5'd11;
  localparam logic [CODE_W-1:0] MID_SO = 5'd12;
  localparam logic [CODE_W-1:0] MID_LA = 5'd13;
  localparam logic [CODE_W-1:0] MID_XI = 5'd14;
  localparam logic [CODE_W-1:0] MAX_DO = 5'd15;
  localparam logic [CODE_W-1:0] MAX_RE = 5'd16;
  localparam logic [CODE_W-1:0] MAX_MI = 5'd17;
  localparam logic [CODE_W-1:0] MAX_FA = 5'd18;
  localparam logic [CODE_W-1:0] MAX_SO = 5'd19;
  localparam logic [CODE_W-1:0] MAX_LA = 5'd20;
  localparam logic [CODE_W-1:0] MAX_XI = 5'd21;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Frequency in Hz of note code 1..21 (low octave doubled per octave step)
  function automatic int unsigned note_freq(input int unsigned code);
    int unsigned base;
    base = 0;
    if (code != 0) begin
      case ((code - 1) % 7)
        0:       base = 262;
        1:       base = 294;
        2:       base = 330;
        3:       base = 349;
        4:       base = 392;
        5:       base = 440;
        default: base = 494;
      endcase
      base = base << ((code - 1) / 7);
    end
    return base;
  endfunction

  function automatic int unsigned nominal_period(input int unsigned clk_hz, input int unsigned code);
    return clk_hz / note_freq(code);
  endfunction

  // Threshold idx separates bin idx (longer periods) from bin idx+1; outer edges are +/-5%
  function automatic logic [PERIOD_W-1:0] bin_threshold(input int unsigned clk_hz, input int unsigned idx);
    int unsigned p;
    if (idx == 0) begin
      p = nominal_period(clk_hz, 1);
      p = p + p / 20;
    end else if (idx >= NUM_NOTES) begin
      p = nominal_period(clk_hz, NUM_NOTES);
      p = p - p / 20;
    end else begin
      p = (nominal_period(clk_hz, idx) + nominal_period(clk_hz, idx + 1)) / 2;
    end
    if (p > (1 << PERIOD_W) - 1) p = (1 << PERIOD_W) - 1;
    return PERIOD_W'(p);
  endfunction

endpackage

// File: rtl/tone_classify.sv
// Maps a measured tone period to a note code via the package thresholds; registered result.
module tone_classify
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample,
  input  logic [PERIOD_W-1:0] period,
  output logic                code_valid,
  output logic [CODE_W-1:0]   code
);

  logic [PERIOD_W-1:0] thr [NUM_THR];

  for (genvar g = 0; g < NUM_THR; g++) begin : g_thr
    localparam logic [PERIOD_W-1:0] THR = bin_threshold(CLK_HZ, g);
    assign thr[g] = THR;
  end

  logic [CODE_W-1:0] code_c;

  always_comb begin
    code_c = NOTE_REST;
    for (int unsigned k = 1; k < NUM_THR; k++) begin
      if (period <= thr[k-1] && period > thr[k]) code_c = CODE_W'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_valid <= 1'b0;
      code       <= NOTE_REST;
    end else begin
      code_valid <= sample;
      if (sample) code <= code_c;
    end
  end

endmodule

// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures rising-edge periods and reports locked notes.
// Optional macro TONE_DECODER_DUR_EN adds per-note duration in milliseconds.
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned STABLE_CNT  = 3,
  parameter int unsigned SILENCE_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tone_in,
  output logic [CODE_W-1:0] note_code,
  output logic              note_valid,
  output logic              note_start,
  output logic              note_end,
  output logic [15:0]       note_dur_ms
);

  localparam int unsigned SIL_W = $clog2(SILENCE_CYC + 1);
  localparam int unsigned STB_W = $clog2(STABLE_CNT + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
  localparam logic [SIL_W-1:0]    SIL_LAST   = SIL_W'(SILENCE_CYC - 1);
  localparam logic [SIL_W-1:0]    SIL_END    = SIL_W'(SILENCE_CYC);
  localparam logic [STB_W-1:0]    STB_N      = STB_W'(STABLE_CNT);

  // sync[1:0] is the synchronizer, sync[2] the edge-detect history
  logic [2:0] sync;
  logic       rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], tone_in};
  end

  assign rise = sync[1] & ~sync[2];

  logic [PERIOD_W-1:0] prd;
  logic [SIL_W-1:0]    sil;
  logic                hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prd   <= '0;
      sil   <= '0;
      hit_q <= 1'b0;
    end else begin
      if (rise)                   prd <= PERIOD_W'(1);
      else if (prd != PERIOD_MAX) prd <= prd + PERIOD_W'(1);
      // Timeout is registered so it lines up with the classifier pipeline; an edge cancels it
      hit_q <= ~rise && (sil == SIL_LAST);
      if (rise)                sil <= '0;
      else if (sil != SIL_END) sil <= sil + SIL_W'(1);
    end
  end

  logic              cls_valid;
  logic [CODE_W-1:0] cls_code;

  tone_classify #(.CLK_HZ(CLK_HZ)) u_classify (
    .clk        (clk),
    .rst        (rst),
    .sample     (rise),
    .period     (prd),
    .code_valid (cls_valid),
    .code       (cls_code)
  );

  logic [1:0]        state, state_n;
  logic [CODE_W-1:0] cand, cand_n;
  logic [STB_W-1:0]  cnt, cnt_n;
  logic              start_c, end_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cand  <= NOTE_REST;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // In LOCKED, cand holds the locked note code
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    start_c = 1'b0;
    end_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cls_valid) begin
          state_n = ST_ACQUIRE;
          cand_n  = NOTE_REST;
          cnt_n   = '0;
        end
      end
      ST_ACQUIRE: begin
        if (hit_q) begin
          state_n = ST_IDLE;
          cand_n  = NOTE_REST;
          cnt_n   = '0;
        end else if (cls_valid) begin
          if (cls_code == NOTE_REST) begin
            cand_n = NOTE_REST;
            cnt_n  = '0;
          end else if (cls_code == cand) begin
            cnt_n = cnt + STB_W'(1);
          end else begin
            cand_n = cls_code;
            cnt_n  = STB_W'(1);
          end
          if (cand_n != NOTE_REST && cnt_n >= STB_N) begin
            state_n = ST_LOCKED;
            start_c = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (hit_q) begin
          state_n = ST_IDLE;
          end_c   = 1'b1;
          cand_n  = NOTE_REST;
          cnt_n   = '0;
        end else if (cls_valid && cls_code != cand) begin
          state_n = ST_ACQUIRE;
          end_c   = 1'b1;
          cand_n  = cls_code;
          cnt_n   = (cls_code == NOTE_REST) ? STB_W'(0) : STB_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cand_n  = NOTE_REST;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_code  <= NOTE_REST;
      note_valid <= 1'b0;
      note_start <= 1'b0;
      note_end   <= 1'b0;
    end else begin
      note_code  <= (state_n == ST_LOCKED) ? cand_n : NOTE_REST;
      note_valid <= (state_n == ST_LOCKED);
      note_start <= start_c;
      note_end   <= end_c;
    end
  end

`ifdef TONE_DECODER_DUR_EN
  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned TICK_W   = $clog2(TICK_DIV + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] pre;
  logic              tick;
  logic [15:0]       ms;

  assign tick = (pre == TICK_LAST);

  // Free-running ms prescaler; the ms counter restarts with each locked note
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre         <= '0;
      ms          <= '0;
      note_dur_ms <= '0;
    end else begin
      pre <= tick ? '0 : pre + TICK_W'(1);
      if (start_c)                                        ms <= '0;
      else if (tick && state == ST_LOCKED && ms != 16'hFFFF) ms <= ms + 16'd1;
      if (end_c) note_dur_ms <= ms;
    end
  end
`else
  assign note_dur_ms = '0;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder using a scaled clock (100 kHz) so runs stay short.
module tb_tone_decoder;

  localparam int CLK_HZ = 100_000;
  localparam int STABLE = 3;
  localparam int SIL    = 1000;
  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

  logic        clk = 1'b0;
  logic        rst;
  logic        tone_in;
  logic [4:0]  note_code;
  logic        note_valid;
  logic        note_start;
  logic        note_end;
  logic [15:0] note_dur_ms;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int edges[$];
  int obs_kind[$], obs_cyc[$], obs_code[$], obs_dur[$];
  int exp_kind[$], exp_cyc[$], exp_code[$], exp_dur[$];

  tone_decoder #(.CLK_HZ(CLK_HZ), .STABLE_CNT(STABLE), .SILENCE_CYC(SIL)) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .note_code   (note_code),
    .note_valid  (note_valid),
    .note_start  (note_start),
    .note_end    (note_end),
    .note_dur_ms (note_dur_ms)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: kind 1 = start, 2 = end
  always @(negedge clk) begin
    if (note_start) begin
      obs_kind.push_back(1); obs_cyc.push_back(cyc);
      obs_code.push_back(int'(note_code)); obs_dur.push_back(0);
    end
    if (note_end) begin
      obs_kind.push_back(2); obs_cyc.push_back(cyc);
      obs_code.push_back(int'(note_code)); obs_dur.push_back(int'(note_dur_ms));
    end
  end

  function automatic real nom(input int k);
    return real'(CLK_HZ) / real'(BASE_HZ[(k - 1) % 7] * (1 << ((k - 1) / 7)));
  endfunction

  function automatic int period_of(input int k);
    return $rtoi(nom(k));
  endfunction

  // Nearest nominal period wins; outside the +/-5% outer edges is a rest
  function automatic int classify(input int p);
    int  best;
    real bd, d;
    best = 0;
    bd   = 1.0e9;
    if (real'(p) > nom(1) * 1.05 || real'(p) < nom(21) * 0.95) return 0;
    for (int k = 1; k <= 21; k++) begin
      d = (real'(p) > nom(k)) ? real'(p) - nom(k) : nom(k) - real'(p);
      if (d < bd) begin bd = d; best = k; end
    end
    return best;
  endfunction

  // A note is any run of >= STABLE equal valid codes; it ends at the next differing period or silence
  function automatic void build_expected();
    int codes[$];
    int a, b, s, e;
    exp_kind.delete(); exp_cyc.delete(); exp_code.delete(); exp_dur.delete();
    for (int i = 1; i < edges.size(); i++) codes.push_back(classify(edges[i] - edges[i-1]));
    a = 0;
    while (a < codes.size()) begin
      b = a;
      while (b + 1 < codes.size() && codes[b+1] == codes[a]) b++;
      if (codes[a] != 0 && b - a + 1 >= STABLE) begin
        s = edges[a + STABLE] + 4;
        e = (b + 1 < codes.size()) ? edges[b + 2] + 4 : edges[edges.size() - 1] + SIL + 4;
        exp_kind.push_back(1); exp_cyc.push_back(s); exp_code.push_back(codes[a]); exp_dur.push_back(0);
        exp_kind.push_back(2); exp_cyc.push_back(e); exp_code.push_back(0);
`ifdef TONE_DECODER_DUR_EN
        exp_dur.push_back((e - s) / MS_CYC);
`else
        exp_dur.push_back(0);
`endif
      end
      a = b + 1;
    end
  endfunction

  // One rising edge, then hold high for hi cycles and low for the rest of the period
  task automatic tone_period(input int p, input int hi);
    tone_in = 1'b1;
    edges.push_back(cyc);
    repeat (hi) @(posedge clk);
    #1 tone_in = 1'b0;
    repeat (p - hi) @(posedge clk);
    #1;
  endtask

  task automatic start_scenario();
    edges.delete();
    obs_kind.delete(); obs_cyc.delete(); obs_code.delete(); obs_dur.delete();
    @(posedge clk); #1;
  endtask

  task automatic go_silent();
    tone_in = 1'b0;
    repeat (SIL + 20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tone_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (note_code !== 5'd0 || note_valid !== 1'b0 || note_start !== 1'b0 ||
        note_end !== 1'b0 || note_dur_ms !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got code=%0d valid=%b start=%b end=%b dur=%0d, expected all 0",
               note_code, note_valid, note_start, note_end, note_dur_ms);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (note_code !== 5'd0 || note_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got code=%0d valid=%b, expected 0/0", note_code, note_valid);
    end
  endtask

  task automatic test_note_523();
    start_scenario();
    for (int i = 0; i < 5; i++) tone_period(191, 23);
    checks++;
    if (note_code !== 5'd8 || note_valid !== 1'b1) begin
      errors++;
      $display("FAIL note_523_lock: got code=%0d valid=%b, expected 8/1", note_code, note_valid);
    end
    go_silent();
    checks++;
    if (note_code !== 5'd0 || note_valid !== 1'b0) begin
      errors++;
      $display("FAIL note_523_silence: got code=%0d valid=%b, expected 0/0", note_code, note_valid);
    end
    build_expected();
    checks++;
    if (obs_kind.size() != exp_kind.size()) begin
      errors++;
      $display("FAIL note_523 events: got %0d expected %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != exp_code[i] ||
          obs_dur[i] > exp_dur[i] + 1 || obs_dur[i] + 1 < exp_dur[i]) begin
        errors++;
        $display("FAIL note_523 ev%0d: got kind=%0d cyc=%0d code=%0d dur=%0d expected %0d/%0d/%0d/%0d",
                 i, obs_kind[i], obs_cyc[i], obs_code[i], obs_dur[i], exp_kind[i], exp_cyc[i], exp_code[i], exp_dur[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_scenario();
    for (int i = 0; i < 59; i++) tone_period(period_of(12), 63);
    for (int i = 0; i < 22; i++) tone_period(period_of(13), int'($urandom_range(1, 112)));
    go_silent();
    build_expected();
    checks++;
    if (obs_kind.size() != exp_kind.size() || exp_kind.size() != 4) begin
      errors++;
      $display("FAIL b2b events: got %0d expected %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != exp_code[i] ||
          obs_dur[i] > exp_dur[i] + 1 || obs_dur[i] + 1 < exp_dur[i]) begin
        errors++;
        $display("FAIL b2b ev%0d: got kind=%0d cyc=%0d code=%0d dur=%0d expected %0d/%0d/%0d/%0d",
                 i, obs_kind[i], obs_cyc[i], obs_code[i], obs_dur[i], exp_kind[i], exp_cyc[i], exp_code[i], exp_dur[i]);
      end
    end
  endtask

  task automatic test_invalid();
    start_scenario();
    for (int i = 0; i < 26; i++) begin
      tone_period((i < 20) ? 30 : 450, 5);
      checks++;
      if (note_code !== 5'd0 || note_valid !== 1'b0) begin
        errors++;
        $display("FAIL invalid_period %0d: got code=%0d valid=%b, expected 0/0", i, note_code, note_valid);
      end
    end
    go_silent();
    checks++;
    if (obs_kind.size() != 0) begin
      errors++;
      $display("FAIL invalid_events: got %0d events expected 0", obs_kind.size());
    end
  endtask

  task automatic test_glitch();
    start_scenario();
    for (int i = 0; i < 6; i++) tone_period(period_of(5), 100);
    tone_period(100, 50);
    for (int i = 0; i < 4; i++) tone_period(period_of(5), 100);
    go_silent();
    build_expected();
    checks++;
    if (obs_kind.size() != exp_kind.size() || exp_kind.size() != 4) begin
      errors++;
      $display("FAIL glitch events: got %0d expected %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != exp_code[i] ||
          obs_dur[i] > exp_dur[i] + 1 || obs_dur[i] + 1 < exp_dur[i]) begin
        errors++;
        $display("FAIL glitch ev%0d: got kind=%0d cyc=%0d code=%0d dur=%0d expected %0d/%0d/%0d/%0d",
                 i, obs_kind[i], obs_cyc[i], obs_code[i], obs_dur[i], exp_kind[i], exp_cyc[i], exp_code[i], exp_dur[i]);
      end
    end
  endtask

  task automatic test_random();
    int k, p, n;
    start_scenario();
    for (int s = 0; s < 20; s++) begin
      k = int'($urandom_range(0, 21));
      n = int'($urandom_range(1, 5));
      for (int j = 0; j < n; j++) begin
        p = (k == 0) ? (($urandom_range(0, 1) != 0) ? 30 : 450)
                     : period_of(k) + int'($urandom_range(0, 2)) - 1;
        tone_period(p, int'($urandom_range(1, p - 1)));
      end
    end
    go_silent();
    build_expected();
    checks++;
    if (obs_kind.size() != exp_kind.size()) begin
      errors++;
      $display("FAIL random events: got %0d expected %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_cyc[i] != exp_cyc[i] || obs_code[i] != exp_code[i] ||
          obs_dur[i] > exp_dur[i] + 1 || obs_dur[i] + 1 < exp_dur[i]) begin
        errors++;
        $display("FAIL random ev%0d: got kind=%0d cyc=%0d code=%0d dur=%0d expected %0d/%0d/%0d/%0d",
                 i, obs_kind[i], obs_cyc[i], obs_code[i], obs_dur[i], exp_kind[i], exp_cyc[i], exp_code[i], exp_dur[i]);
      end
    end
  endtask

  task automatic test_reset_mid_note();
    start_scenario();
    for (int i = 0; i < 6; i++) tone_period(period_of(5), 100);
    checks++;
    if (note_code !== 5'd5 || note_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: got code=%0d valid=%b, expected 5/1", note_code, note_valid);
    end
    tone_in = 1'b1;
    repeat (40) @(posedge clk);
    obs_kind.delete(); obs_cyc.delete(); obs_code.delete(); obs_dur.delete();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (note_code !== 5'd0 || note_valid !== 1'b0 || note_start !== 1'b0 ||
        note_end !== 1'b0 || note_dur_ms !== 16'd0) begin
      errors++;
      $display("FAIL mid_note_reset: got code=%0d valid=%b start=%b end=%b dur=%0d, expected all 0",
               note_code, note_valid, note_start, note_end, note_dur_ms);
    end
    tone_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    go_silent();
    checks++;
    if (obs_kind.size() != 0) begin
      errors++;
      $display("FAIL reset_no_end: got %0d events expected 0", obs_kind.size());
    end
    start_scenario();
    for (int i = 0; i < 5; i++) tone_period(period_of(5), 30);
    checks++;
    if (note_code !== 5'd5 || note_valid !== 1'b1 || obs_kind.size() != 1 ||
        (obs_kind.size() == 1 && obs_cyc[0] != edges[3] + 4)) begin
      errors++;
      $display("FAIL resume_after_reset: got code=%0d valid=%b events=%0d, expected 5/1/1 at %0d",
               note_code, note_valid, obs_kind.size(), edges[3] + 4);
    end
    go_silent();
  endtask

  initial begin
    rst = 1'b1;
    tone_in = 1'b0;
    test_reset();
    test_note_523();
    test_back_to_back();
    test_invalid();
    test_glitch();
    test_random();
    test_reset_mid_note();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
# tone_decoder

Receive-side counterpart of the melody/beep generator: samples a square-wave tone line (e.g. the `beep` pin looped back, or an external buzzer drive), measures the period between rising edges, and classifies each period as one of 21 notes (low/mid/high DO..XI). It runs in the same 100 MHz domain and reports note start/end events, the current note code and, optionally, each note's duration in milliseconds, so that played melodies can be self-checked on the board.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency; sets the 1 ms tick.
- `STABLE_CNT`, 3: consecutive matching periods required before a note is declared.
- `SILENCE_CYC`, 1_000_000: cycles without a rising edge that end a note (10 ms; must exceed 400_000).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `tone_in`  in  1  asynchronous square-wave input, any duty cycle.
- `note_code`  out  5  current note: 0 = rest, 1..7 low DO..XI, 8..14 mid, 15..21 high.
- `note_valid`  out  1  high while a note is locked.
- `note_start`  out  1  one-cycle pulse when a note locks.
- `note_end`  out  1  one-cycle pulse when a locked note ends.
- `note_dur_ms`  out  16  duration of the note just ended; valid with `note_end` (NOTE_DUR_EN only).

## Operation
- Input path: 2-FF synchronizer on `tone_in`, then rising-edge detect. Only rising edges are used; duty cycle is irrelevant.
- Period counter (20 bit): cleared to 1 on each edge, increments otherwise, saturates at 2^20-1. On each edge after the first, the captured period is classified.
- Classification: period compared against 22 thresholds from the package. Bin k holds periods between the midpoints to its neighbours. Nominal periods are CLK_HZ/f for 262, 294, 330, 349, 392, 440, 494 Hz and their ×2 and ×4. Outer edges are nominal ±5%. A period outside all bins is code 0 (invalid).
- FSM states:
  - IDLE: no tone. First edge goes to ACQUIRE with cand=none, cnt=0.
  - ACQUIRE: on each classified period: invalid → cnt=0; equal to cand → cnt+1; otherwise cand=new code, cnt=1. When cnt reaches STABLE_CNT → LOCKED, `note_code`=cand, pulse `note_start`.
  - LOCKED: matching period → stay. Mismatch (including invalid) → pulse `note_end`, go to ACQUIRE with cand=new code, cnt=1 (cnt=0 if invalid).
  - Any state: SILENCE_CYC cycles since the last edge → IDLE. If LOCKED, pulse `note_end`.
- `note_code` reads 0 whenever not LOCKED. `note_valid` = (state == LOCKED).

## Timing
- Reset: state IDLE; all counters 0; `note_code`=0; `note_valid`, `note_start`, `note_end` = 0; `note_dur_ms`=0. Reset mid-note aborts it without a `note_end`.
- Latency: a `tone_in` edge is seen 3 cycles later (2 sync + 1 edge detect). Classification is registered, adding 1 cycle. `note_start`/`note_end` assert 4 cycles after the deciding `tone_in` edge.
- Silence fires on exactly the SILENCE_CYC-th cycle after the last detected edge.
- An edge and the silence timeout in the same cycle: the edge wins and the timeout counter resets.
- `note_end` and `note_start` never assert in the same cycle.

## Configuration
- `TONE_DECODER_DUR_EN` defined:
  - A ms prescaler counts 0..CLK_HZ/1000-1; a 16-bit ms counter clears on `note_start` and increments on each tick while LOCKED, saturating at 65535.
  - `note_dur_ms` loads the count on `note_end` and holds it.
- Undefined: the prescaler and counter are removed; `note_dur_ms` is tied to 0.

## Structure
- Package `tone_pkg`: note code constants (`NOTE_REST`, `MIN_DO`..`MAX_XI` as codes 0..21), nominal period table, bin threshold table, FSM state enum.
- One sub-module `tone_classify`: pure period→code lookup plus an output register. The FSM, counters and synchronizer live in the top level.

## Test plan
- 523 Hz square wave (period 191_205), 12.5% duty, 5 edges → `note_start` after the 4th edge + 4 cycles, `note_code`=8, `note_valid`=1.
- Stop the input after the 523 Hz tone → `note_end` exactly 1_000_000 cycles after the last edge; `note_code`=0; with DUR_EN, `note_dur_ms` equals the elapsed time ±1.
- 784 Hz for 750 ms, then 880 Hz for 250 ms → codes 12 then 13; `note_end`/`note_start` in separate cycles; with DUR_EN, the first `note_dur_ms`≈750.
- Period 30_000 (out of range), repeated → never locks; `note_code` stays 0.
- Locked 392 Hz (code 5), one glitch period of 100_000 → `note_end`, re-acquire; lock again after 3 good periods.
- Assert `rst` mid-note → all outputs 0 on the next edge of `clk`, no `note_end` pulse; decoding resumes normally after release.
